// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which core port owns the transaction in flight
//   mem_req_t   : request fields latched at grant time
//   cnt_width() : width of the starvation counter for a given limit
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
        logic        read;
        logic        write;
    } mem_req_t;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant decision for the memory port arbiter.
//   i_instr_req  : instruction fetch pending
//   i_data_req   : load or store pending
//   i_starve_cnt : consecutive data grants made while a fetch waited
//   o_grant      : some request is pending
//   o_grant_d    : 1 = grant data side, 0 = grant instruction side
module arb_grant_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 2,
    parameter int CNT_W        = 2
) (
    input  logic             i_instr_req,
    input  logic             i_data_req,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output logic             o_grant,
    output logic             o_grant_d
);

    logic w_starved;

    // Fetch has watched the limit of data grants go by: it wins this round.
    assign w_starved = i_instr_req && (i_starve_cnt == CNT_W'(STARVE_LIMIT));
    assign o_grant   = i_instr_req | i_data_req;
    assign o_grant_d = i_data_req & ~w_starved;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's instruction-fetch and load/store ports onto one
// shared word-wide memory port, one transaction at a time. Data requests
// win unless a fetch has waited through STARVE_LIMIT data grants.
//   clk, rst               : clock, asynchronous active-low reset
//   instr_*                : fetch request/address in, resp/rdata out
//   data_*                 : load/store request, mbe, address, wdata in,
//                            resp/rdata out
//   mem_*  (outputs)       : shared-port read/write strobes, mbe, address,
//                            wdata, all driven straight from registers
//   mem_resp, mem_rdata    : shared-port completion and read data
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [31:0] instr_mem_address,
    output logic        instr_mem_resp,
    output logic [31:0] instr_mem_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_mem_address,
    input  logic [31:0] data_mem_wdata,
    output logic        data_mem_resp,
    output logic [31:0] data_mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_mbe,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = cnt_width(STARVE_LIMIT);

    arb_state_t       r_state;
    arb_owner_t       r_owner;
    mem_req_t         r_req;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [31:0]      r_rdata_q;
    logic             r_instr_resp;
    logic             r_data_resp;

    logic w_data_req;
    logic w_grant;
    logic w_grant_d;

    assign w_data_req = data_read | data_write;

    arb_grant_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_grant_sel (
        .i_instr_req  (instr_read),
        .i_data_req   (w_data_req),
        .i_starve_cnt (r_starve_cnt),
        .o_grant      (w_grant),
        .o_grant_d    (w_grant_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_I;
            r_req        <= '0;
            r_starve_cnt <= '0;
            r_rdata_q    <= '0;
            r_instr_resp <= 1'b0;
            r_data_resp  <= 1'b0;
        end else begin
            r_instr_resp <= 1'b0;
            r_data_resp  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant && w_grant_d) begin
                        r_state     <= D_BUSY;
                        r_owner     <= OWN_D;
                        // Read and write together is taken as a write.
                        r_req.addr  <= data_mem_address;
                        r_req.wdata <= data_mem_wdata;
                        r_req.mbe   <= data_mbe;
                        r_req.read  <= ~data_write;
                        r_req.write <= data_write;
                        if (!instr_read) begin
                            r_starve_cnt <= '0;
                        end else if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else if (w_grant) begin
                        r_state      <= I_BUSY;
                        r_owner      <= OWN_I;
                        // Fetches are full-word reads.
                        r_req.addr   <= instr_mem_address;
                        r_req.wdata  <= '0;
                        r_req.mbe    <= 4'hF;
                        r_req.read   <= 1'b1;
                        r_req.write  <= 1'b0;
                        r_starve_cnt <= '0;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_resp) begin
                        r_state     <= DONE;
                        r_rdata_q   <= mem_rdata;
                        r_req.read  <= 1'b0;
                        r_req.write <= 1'b0;
                        if (r_owner == OWN_D) r_data_resp  <= 1'b1;
                        else                  r_instr_resp <= 1'b1;
                    end
                end
                // Core requests are not sampled here, giving the core a
                // cycle to drop or replace its request.
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_read        = r_req.read;
    assign mem_write       = r_req.write;
    assign mem_mbe         = r_req.mbe;
    assign mem_address     = r_req.addr;
    assign mem_wdata       = r_req.wdata;
    assign instr_mem_resp  = r_instr_resp;
    assign data_mem_resp   = r_data_resp;
    assign instr_mem_rdata = r_rdata_q;
    assign data_mem_rdata  = r_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A transaction-level timeline model
// predicts, for each grant, the owner and the cycles in which the strobe and
// the core response must appear; directed sections follow for reset and the
// lone fetch / store cases.
module tb_mem_port_arbiter;

    localparam int LIMIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_read = 1'b0;
    logic [31:0] instr_mem_address = '0;
    logic        instr_mem_resp;
    logic [31:0] instr_mem_rdata;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [3:0]  data_mbe = '0;
    logic [31:0] data_mem_address = '0;
    logic [31:0] data_mem_wdata = '0;
    logic        data_mem_resp;
    logic [31:0] data_mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk               (clk),
        .rst               (rst),
        .instr_read        (instr_read),
        .instr_mem_address (instr_mem_address),
        .instr_mem_resp    (instr_mem_resp),
        .instr_mem_rdata   (instr_mem_rdata),
        .data_read         (data_read),
        .data_write        (data_write),
        .data_mbe          (data_mbe),
        .data_mem_address  (data_mem_address),
        .data_mem_wdata    (data_mem_wdata),
        .data_mem_resp     (data_mem_resp),
        .data_mem_rdata    (data_mem_rdata),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_mbe           (mem_mbe),
        .mem_address       (mem_address),
        .mem_wdata         (mem_wdata),
        .mem_resp          (mem_resp),
        .mem_rdata         (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " mem_read"},   32'(mem_read), 0);
        check_eq({tag, " mem_write"},  32'(mem_write), 0);
        check_eq({tag, " mem_mbe"},    32'(mem_mbe), 0);
        check_eq({tag, " mem_address"}, mem_address, 0);
        check_eq({tag, " mem_wdata"},  mem_wdata, 0);
        check_eq({tag, " instr_resp"}, 32'(instr_mem_resp), 0);
        check_eq({tag, " data_resp"},  32'(data_mem_resp), 0);
        check_eq({tag, " instr_rdata"}, instr_mem_rdata, 0);
        check_eq({tag, " data_rdata"}, data_mem_rdata, 0);
    endtask

    task automatic new_instr();
        instr_read        = 1'b1;
        instr_mem_address = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic new_data();
        int op;
        op               = $urandom_range(0, 2);   // 0 load, 1 store, 2 both
        data_read        = (op != 1);
        data_write       = (op != 0);
        data_mbe         = 4'($urandom);
        data_mem_address = $urandom & 32'hFFFF_FFFC;
        data_mem_wdata   = $urandom;
    endtask

    // Timeline model state: the transaction in flight and when the port
    // frees up again (grant + latency + strobe cycle + DONE cycle).
    bit          have_t = 0;
    int          t_g, t_L;
    bit          t_d, t_wr;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [3:0]  t_mbe;
    int          free_c = 0;
    int          starve = 0;

    bit phase1, quiesce, exp_strobe, exp_resp, i_busy, d_busy;

    initial begin
        #1;
        check_all_zero("reset");
        @(negedge clk);
        check_all_zero("reset held");
        rst = 1'b1;

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            phase1  = (c < 60);
            quiesce = (c >= 550);

            exp_strobe = have_t && (c >= t_g + 1) && (c <= t_g + t_L);
            exp_resp   = have_t && (c == t_g + t_L + 1);

            check_eq("mem_read",  32'(mem_read),  32'(exp_strobe && !t_wr));
            check_eq("mem_write", 32'(mem_write), 32'(exp_strobe && t_wr));
            if (exp_strobe) begin
                check_eq("mem_address", mem_address, t_addr);
                check_eq("mem_mbe", 32'(mem_mbe), 32'(t_mbe));
                if (t_wr) check_eq("mem_wdata", mem_wdata, t_wdata);
            end
            check_eq("instr_resp", 32'(instr_mem_resp), 32'(exp_resp && !t_d));
            check_eq("data_resp",  32'(data_mem_resp),  32'(exp_resp && t_d));
            if (exp_resp && !t_wr) begin
                if (t_d) check_eq("data_rdata", data_mem_rdata, t_rdata);
                else     check_eq("instr_rdata", instr_mem_rdata, t_rdata);
            end

            // Memory side: answer at the chosen latency, otherwise
            // occasionally pulse mem_resp where it must be ignored.
            mem_rdata = $urandom;
            if (exp_strobe && c == t_g + t_L) begin
                mem_resp = 1'b1;
                t_rdata  = mem_rdata;
            end else begin
                mem_resp = !exp_strobe && ($urandom_range(0, 5) == 0);
            end

            // Core side.
            i_busy = have_t && !t_d && (c <= t_g + t_L + 1);
            d_busy = have_t &&  t_d && (c <= t_g + t_L + 1);
            if (exp_resp) begin
                if (!quiesce && (phase1 || $urandom_range(0, 1) == 1)) begin
                    if (t_d) new_data(); else new_instr();
                end else begin
                    if (t_d) begin data_read = 1'b0; data_write = 1'b0; end
                    else instr_read = 1'b0;
                end
            end else if (exp_strobe && !phase1 && $urandom_range(0, 15) == 0) begin
                if (t_d) begin data_read = 1'b0; data_write = 1'b0; end
                else instr_read = 1'b0;
            end
            if (!instr_read && !i_busy && !quiesce && (phase1 || $urandom_range(0, 3) == 0))
                new_instr();
            if (!data_read && !data_write && !d_busy && !quiesce && (phase1 || $urandom_range(0, 3) == 0))
                new_data();

            // Grant prediction from the priority and starvation rules.
            if (c >= free_c && (instr_read || data_read || data_write)) begin
                t_d = (data_read || data_write) && !(instr_read && starve == LIMIT);
                if (t_d) starve = instr_read ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
                else     starve = 0;
                t_g    = c;
                t_L    = phase1 ? 1 : $urandom_range(1, 5);
                t_wr   = t_d && data_write;
                t_addr = t_d ? data_mem_address : instr_mem_address;
                t_wdata = data_mem_wdata;
                t_mbe  = t_d ? data_mbe : 4'hF;
                free_c = c + t_L + 2;
                have_t = 1;
            end
        end

        // Reset during a load in D_BUSY.
        @(negedge clk);
        mem_resp = 1'b0;
        instr_read = 1'b0; data_write = 1'b0;
        data_read = 1'b1; data_mem_address = 32'h200; data_mbe = 4'hF;
        @(negedge clk);
        check_eq("rst load strobe", 32'(mem_read), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("rst async mem_read", 32'(mem_read), 0);
        check_eq("rst async address", mem_address, 0);
        check_eq("rst async data_resp", 32'(data_mem_resp), 0);
        data_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("after rst");
        check_eq("after rst no resp", 32'(data_mem_resp), 0);

        // Spurious mem_resp in IDLE, then a lone fetch with 3-cycle memory.
        mem_resp = 1'b1;
        @(negedge clk);
        check_eq("spurious strobe", 32'(mem_read | mem_write), 0);
        mem_resp = 1'b0;
        instr_read = 1'b1; instr_mem_address = 32'h60;
        @(negedge clk);
        check_eq("fetch mem_read", 32'(mem_read), 1);
        check_eq("fetch address", mem_address, 32'h60);
        @(negedge clk);
        check_eq("fetch held", 32'(mem_read), 1);
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        mem_resp = 1'b0;
        check_eq("fetch resp", 32'(instr_mem_resp), 1);
        check_eq("fetch rdata", instr_mem_rdata, 32'h0000_0013);
        check_eq("fetch no data_resp", 32'(data_mem_resp), 0);
        check_eq("fetch strobe off", 32'(mem_read), 0);
        instr_read = 1'b0;
        @(negedge clk);
        check_eq("fetch resp one cycle", 32'(instr_mem_resp), 0);

        // Directed store.
        data_write = 1'b1; data_read = 1'b0;
        data_mem_address = 32'h1004; data_mem_wdata = 32'hDEAD_BEEF; data_mbe = 4'b1100;
        @(negedge clk);
        check_eq("store mem_write", 32'(mem_write), 1);
        check_eq("store mem_read", 32'(mem_read), 0);
        check_eq("store address", mem_address, 32'h1004);
        check_eq("store wdata", mem_wdata, 32'hDEAD_BEEF);
        check_eq("store mbe", 32'(mem_mbe), 32'hC);
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        check_eq("store resp", 32'(data_mem_resp), 1);
        check_eq("store no instr_resp", 32'(instr_mem_resp), 0);
        data_write = 1'b0;
        @(negedge clk);
        check_eq("store resp one cycle", 32'(data_mem_resp), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
